// File: rtl/ctrl_bubble_pipe_if.sv
// Bundle of the control-pipeline signals between the ID stage/hazard unit
// and the control-bundle pipeline.
//   master : ID side (drives ctrl_in, ctrl_valid_in, bubble_req, bubble_len,
//            flush; observes ctrl_out, valid_out, stall_upstream, bubble_count)
//   slave  : pipeline side (the reverse directions)
interface ctrl_bubble_pipe_if #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned LEN_W  = 3,
  parameter int unsigned STAT_W = 16
);
  logic [CTRL_W-1:0]       ctrl_in;
  logic                    ctrl_valid_in;
  logic                    bubble_req;
  logic [LEN_W-1:0]        bubble_len;
  logic                    flush;
  logic [DEPTH*CTRL_W-1:0] ctrl_out;
  logic [DEPTH-1:0]        valid_out;
  logic                    stall_upstream;
  logic [STAT_W-1:0]       bubble_count;

  modport master (
    output ctrl_in, ctrl_valid_in, bubble_req, bubble_len, flush,
    input  ctrl_out, valid_out, stall_upstream, bubble_count
  );

  modport slave (
    input  ctrl_in, ctrl_valid_in, bubble_req, bubble_len, flush,
    output ctrl_out, valid_out, stall_upstream, bubble_count
  );
endinterface

// File: rtl/ctrl_bubble_pipe.sv
// Control-bundle pipeline for ID->EX->MEM->WB. Carries the decoded control
// bundle through DEPTH registered stages, inserts multi-cycle bubbles on
// hazard requests (holding upstream while they issue), zeroes the youngest
// FLUSH_DEPTH stages on flush and keeps a saturating count of bubbles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : ctrl_bubble_pipe_if.slave
//           in  ctrl_in, ctrl_valid_in, bubble_req, bubble_len, flush
//           out ctrl_out (stage k at [k*CTRL_W +: CTRL_W]), valid_out,
//               stall_upstream (combinational), bubble_count
module ctrl_bubble_pipe #(
  parameter int unsigned CTRL_W      = 9,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned LEN_W       = 3,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  ctrl_bubble_pipe_if.slave bus
);

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  logic [CTRL_W-1:0] r_stage [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [LEN_W-1:0]  r_bub_cnt;       // bubbles remaining after the current one
  logic [STAT_W-1:0] r_bubble_count;

  logic              w_bubbling;
  logic              w_start;
  logic [LEN_W-1:0]  w_run_rem;

  // Flush overrides any bubble request or run in progress.
  assign w_bubbling = !bus.flush && ((r_bub_cnt != '0) || bus.bubble_req);
  assign w_start    = (r_bub_cnt == '0) && bus.bubble_req && !bus.flush;
  // A length of 0 behaves as 1; the current cycle is already one bubble.
  assign w_run_rem  = (bus.bubble_len == '0) ? '0 : bus.bubble_len - LEN_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_stage[k] <= '0;
      r_valid        <= '0;
      r_bub_cnt      <= '0;
      r_bubble_count <= '0;
    end else begin
      if (bus.flush)
        r_bub_cnt <= '0;
      else if (w_start)
        r_bub_cnt <= w_run_rem;
      else if (r_bub_cnt != '0)
        r_bub_cnt <= r_bub_cnt - LEN_ONE;

      if (w_bubbling && (r_bubble_count != '1))
        r_bubble_count <= r_bubble_count + STAT_ONE;

      if (bus.flush || w_bubbling || !bus.ctrl_valid_in) begin
        r_stage[0] <= '0;
        r_valid[0] <= 1'b0;
      end else begin
        r_stage[0] <= bus.ctrl_in;
        r_valid[0] <= 1'b1;
      end

      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (bus.flush && (k < FLUSH_DEPTH)) begin
          r_stage[k] <= '0;
          r_valid[k] <= 1'b0;
        end else begin
          r_stage[k] <= r_stage[k-1];
          r_valid[k] <= r_valid[k-1];
        end
      end
    end
  end

  // Gated by reset so a request seen during reset never holds the front end.
  assign bus.stall_upstream = w_bubbling && !reset;
  assign bus.valid_out      = r_valid;
  assign bus.bubble_count   = r_bubble_count;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign bus.ctrl_out[g*CTRL_W +: CTRL_W] = r_stage[g];
  end

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Scoreboard bench for ctrl_bubble_pipe: the driver applies stimulus, works
// out the expected outputs from a stage-list/run-length reference model and
// queues them; a monitor pops and compares at each falling edge.
module tb_ctrl_bubble_pipe;
  localparam int CW = 9;
  localparam int D  = 3;
  localparam int FD = 2;
  localparam int LW = 3;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_bubble_pipe_if #(.CTRL_W(CW), .DEPTH(D), .LEN_W(LW), .STAT_W(SW)) bus ();

  ctrl_bubble_pipe #(
    .CTRL_W(CW), .DEPTH(D), .FLUSH_DEPTH(FD), .LEN_W(LW), .STAT_W(SW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [D*CW-1:0] ctrl;
    logic [D-1:0]    valid;
    logic            stall;
    logic [SW-1:0]   cnt;
    int              cyc;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model state
  logic [CW-1:0] m_ctrl  [D];
  logic          m_valid [D];
  int unsigned   m_rem;   // bubble cycles still owed, including the current one
  int unsigned   m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int c, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < D; k++) begin
      m_ctrl[k]  = '0;
      m_valid[k] = 1'b0;
    end
    m_rem = 0;
    m_cnt = 0;
  endtask

  task automatic step(input logic rst, input logic [CW-1:0] c, input logic v,
                      input logic br, input logic [LW-1:0] bl, input logic fl);
    exp_t e;
    logic bub;
    @(posedge clk);
    #1;
    reset             = rst;
    bus.ctrl_in       = c;
    bus.ctrl_valid_in = v;
    bus.bubble_req    = br;
    bus.bubble_len    = bl;
    bus.flush         = fl;

    bub = !rst && !fl && (m_rem > 0 || br);
    for (int k = 0; k < D; k++) begin
      e.ctrl[k*CW +: CW] = m_ctrl[k];
      e.valid[k]         = m_valid[k];
    end
    e.stall = bub;
    e.cnt   = SW'(m_cnt);
    e.cyc   = cyc;
    expq.push_back(e);

    if (rst) begin
      model_clear();
    end else begin
      if (fl) m_rem = 0;
      else if (bub) begin
        if (m_rem == 0) m_rem = (bl == 0) ? 1 : int'(bl);
        m_rem--;
      end
      if (bub && m_cnt < (1 << SW) - 1) m_cnt++;
      for (int k = D - 1; k >= 1; k--) begin
        if (fl && k < FD) begin
          m_ctrl[k] = '0; m_valid[k] = 1'b0;
        end else begin
          m_ctrl[k] = m_ctrl[k-1]; m_valid[k] = m_valid[k-1];
        end
      end
      if (fl || bub || !v) begin
        m_ctrl[0] = '0; m_valid[0] = 1'b0;
      end else begin
        m_ctrl[0] = c; m_valid[0] = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic [CW-1:0] c, input int n);
    for (int i = 0; i < n; i++) step(1'b0, c, 1'b1, 1'b0, '0, 1'b0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ctrl_out",       e.cyc, 64'(bus.ctrl_out),       64'(e.ctrl));
        chk("valid_out",      e.cyc, 64'(bus.valid_out),      64'(e.valid));
        chk("stall_upstream", e.cyc, 64'(bus.stall_upstream), 64'(e.stall));
        chk("bubble_count",   e.cyc, 64'(bus.bubble_count),   64'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.ctrl_in = '0; bus.ctrl_valid_in = 1'b0; bus.bubble_req = 1'b0;
    bus.bubble_len = '0; bus.flush = 1'b0;
    model_clear();
    @(posedge clk);

    // Reset with garbage inputs, then a stream of 1A5
    for (int i = 0; i < 3; i++)
      step(1'b1, CW'($urandom), 1'b1, 1'b1, LW'($urandom), 1'b0);
    idle(9'h1A5, 4);

    // Load-use: single bubble with len 0
    step(1'b0, 9'h0F3, 1'b1, 1'b1, 3'd0, 1'b0);
    idle(9'h0F3, 3);

    // Multi-bubble len 3, request re-pulsed on 2nd cycle with another length
    step(1'b0, 9'h055, 1'b1, 1'b1, 3'd3, 1'b0);
    step(1'b0, 9'h055, 1'b1, 1'b1, 3'd7, 1'b0);
    step(1'b0, 9'h055, 1'b1, 1'b0, 3'd0, 1'b0);
    idle(9'h055, 3);

    // Flush on 2nd cycle of a len-5 run
    idle(9'h1C7, 3);
    step(1'b0, 9'h1C7, 1'b1, 1'b1, 3'd5, 1'b0);
    step(1'b0, 9'h1C7, 1'b1, 1'b0, 3'd0, 1'b1);
    idle(9'h0AA, 4);

    // Simultaneous request and flush
    step(1'b0, 9'h123, 1'b1, 1'b1, 3'd4, 1'b1);
    idle(9'h123, 3);

    // Maximum length run
    step(1'b0, 9'h0E1, 1'b1, 1'b1, 3'd7, 1'b0);
    idle(9'h0E1, 9);

    // Saturation
    step(1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 9'h010, 1'b1, 1'b1, 3'd1, 1'b0);
      step(1'b0, 9'h010, 1'b1, 1'b0, 3'd0, 1'b0);
    end
    idle(9'h010, 1);
    @(negedge clk);
    chk("sat_hold", cyc, 64'(bus.bubble_count), 64'd15);
    step(1'b1, 9'h1FF, 1'b1, 1'b1, 3'd3, 1'b0);
    idle(9'h000, 1);
    @(negedge clk);
    chk("sat_reset", cyc, 64'(bus.bubble_count), 64'd0);

    // Reset in the middle of a run
    step(1'b0, 9'h0B2, 1'b1, 1'b1, 3'd6, 1'b0);
    step(1'b0, 9'h0B2, 1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 9'h0B2, 1'b1, 1'b0, 3'd0, 1'b0);
    idle(9'h0B2, 3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           CW'($urandom),
           ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 20),
           LW'($urandom),
           ($urandom_range(0, 99) < 8));
    end
    idle(9'h000, 2);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      n_checks++;
      $display("FAIL drain got=%0d pending exp=0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
